// File: rtl/nios_entity_pkg.sv
// Shared constants and types for the Nios entity PIO slaves.
// Register map, edge-type encodings and the Avalon data word.
package nios_entity_pkg;

  typedef logic [31:0] avalon_word_t;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_RSVD    = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/nios_system_entity_status_in_if.sv
// Avalon-MM slave bus bundle for the entity status input port.
// The master drives the request; the slave returns readdata.
interface nios_system_entity_status_in_if;
  import nios_entity_pkg::*;

  logic [1:0]   address;
  logic         chipselect;
  logic         write_n;
  avalon_word_t writedata;
  avalon_word_t readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );

endinterface

// File: rtl/entity_status_debounce.sv
// One-bit debouncer: accepts a new level after it has differed
// from the accepted value for DEBOUNCE_CYCLES consecutive clocks.
module entity_status_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic stable
);

  localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

  logic [15:0] cnt_q, cnt_d;
  logic        acc_q, acc_d;

  // Count consecutive mismatch cycles; restart on any agreement.
  always_comb begin
    cnt_d = cnt_q;
    acc_d = acc_q;
    if (raw == acc_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      acc_d = raw;
    end else begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // Counter and accepted-level state.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      acc_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
    end
  end

  assign stable = acc_q;

endmodule

// File: rtl/nios_system_entity_status_in.sv
// Avalon-MM PIO-in slave with edge capture and maskable irq.
// Define ENTITY_STATUS_DEBOUNCE_EN to debounce each input bit.
module nios_system_entity_status_in
  import nios_entity_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int EDGE_TYPE       = 0,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  nios_system_entity_status_in_if.slave bus,
  input  logic [WIDTH-1:0]            in_port,
  output logic                        irq
);

  logic [WIDTH-1:0] sync_s1_q, sync_s1_d;
  logic [WIDTH-1:0] sync_s2_q, sync_s2_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] irqmask_q, irqmask_d;
  logic [WIDTH-1:0] edgecap_q, edgecap_d;
  logic             irq_q, irq_d;

  logic [WIDTH-1:0] level;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] wdata;
  logic             wr_en;
  logic             wr_mask;
  logic             wr_clr;
  logic             unused_wd;

`ifdef ENTITY_STATUS_DEBOUNCE_EN
  for (genvar i = 0; i < WIDTH; i++) begin : g_db
    entity_status_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk   (clk),
      .reset (reset),
      .raw   (sync_s2_q[i]),
      .stable(level[i])
    );
  end
`else
  assign level = sync_s2_q;
`endif

  assign wdata     = bus.writedata[WIDTH-1:0];
  assign unused_wd = ^bus.writedata;
  assign wr_en     = bus.chipselect & ~bus.write_n;
  assign wr_mask   = wr_en & (bus.address == ADDR_IRQMASK);
  assign wr_clr    = wr_en & (bus.address == ADDR_EDGECAP);

  // Select which transitions of the accepted level are edges.
  always_comb begin
    rise     = level & ~prev_q;
    fall     = ~level & prev_q;
    edge_det = rise;
    if (EDGE_TYPE == EDGE_FALL) begin
      edge_det = fall;
    end else if (EDGE_TYPE == EDGE_ANY) begin
      edge_det = rise | fall;
    end
  end

  // Next state: sync chain, mask load, clear-then-set capture, irq.
  always_comb begin
    sync_s1_d = in_port;
    sync_s2_d = sync_s1_q;
    prev_d    = level;
    irqmask_d = wr_mask ? wdata : irqmask_q;
    edgecap_d = edgecap_q;
    if (wr_clr) begin
      edgecap_d = edgecap_q & ~wdata;
    end
    edgecap_d = edgecap_d | edge_det;
    irq_d     = |(edgecap_q & irqmask_q);
  end

  // Register state; reset flushes sync history and pending captures.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_s1_q <= '0;
      sync_s2_q <= '0;
      prev_q    <= '0;
      irqmask_q <= '0;
      edgecap_q <= '0;
      irq_q     <= 1'b0;
    end else begin
      sync_s1_q <= sync_s1_d;
      sync_s2_q <= sync_s2_d;
      prev_q    <= prev_d;
      irqmask_q <= irqmask_d;
      edgecap_q <= edgecap_d;
      irq_q     <= irq_d;
    end
  end

  // Zero-wait-state read mux, zero-extended to the bus width.
  always_comb begin
    bus.readdata = '0;
    unique case (1'b1)
      (bus.address == ADDR_DATA):
        bus.readdata[WIDTH-1:0] = level;
      (bus.address == ADDR_RSVD):
        bus.readdata = '0;
      (bus.address == ADDR_IRQMASK):
        bus.readdata[WIDTH-1:0] = irqmask_q;
      (bus.address == ADDR_EDGECAP):
        bus.readdata[WIDTH-1:0] = edgecap_q;
      default:
        bus.readdata = '0;
    endcase
  end

  assign irq = irq_q;

endmodule
